lfsr_gen: RTL and testbench
===========================

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 The block SHALL have parameter LFSR_WIDTH, default 16, meaning register length with legal range 4..32.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 16, meaning output bits with legal range 1..LFSR_WIDTH.
REQ-003 The block SHALL have parameter STEPS, default 1, meaning LFSR shifts per enabled cycle with legal range 1..LFSR_WIDTH.
REQ-004 The block SHALL have parameter SEED, default 1, meaning reset and recovery state, with width LFSR_WIDTH; it SHALL be nonzero.
REQ-005 The block SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-006 The block SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port en_i, input, 1 bit: advance the LFSR by STEPS this cycle.
REQ-008 The block SHALL have port load_i, input, 1 bit: load seed_i this cycle.
REQ-009 The block SHALL have port seed_i, input, LFSR_WIDTH bits: runtime seed.
REQ-010 The block SHALL have port out_o, output, OUT_WIDTH bits: state[OUT_WIDTH-1:0].
REQ-011 The block SHALL have port lockup_o, output, 1 bit: one-cycle pulse when the all-zero state is replaced.
REQ-012 The block SHALL have port wrap_o, output, 1 bit: one-cycle pulse when the state returns to the last loaded seed.

Function
REQ-013 Step SHALL be Fibonacci XOR form: state <= {state[W-2:0], fb}, where fb is the XOR of the tap bits taken from the package tap table for LFSR_WIDTH.
REQ-014 en_i=1 SHALL apply STEPS chained steps in one cycle, with the result registered; the output SHALL show the new state 1 cycle after en_i.
REQ-015 en_i=0 and load_i=0 SHALL hold the state.
REQ-016 load_i SHALL have priority over en_i.
REQ-017 On load with both asserted, the state SHALL become seed_i and no step SHALL be applied that cycle.
REQ-018 A load of seed_i==0 SHALL load SEED instead and pulse lockup_o the next cycle.
REQ-019 If the state is ever all-zero, the next edge SHALL force SEED regardless of en_i and pulse lockup_o for 1 cycle.
REQ-020 out_o SHALL be driven directly from the state register, with no combinational path from inputs.
REQ-021 wrap_o SHALL assert for 1 cycle in the cycle after a step lands on seed_q, where seed_q is the last effective loaded seed (SEED after reset).
REQ-022 wrap_o SHALL NOT assert on a load or on a recovery.
REQ-023 With STEPS>1, wrap SHALL be checked only against the post-STEPS state; intermediate matches SHALL be ignored.

Reset
REQ-024 rst_ni low SHALL asynchronously set state=SEED, seed_q=SEED, lockup_o=0 and wrap_o=0.
REQ-025 Reset release SHALL be synchronous to clk_i; the first step SHALL occur on the first edge with en_i=1 after release.
REQ-026 Reset mid-stream SHALL discard any pending load or step.

Configuration
REQ-027 Macro LFSR_WRAP_DETECT_EN defined SHALL build the seed_q register, the comparator and the wrap_o logic per REQ-021..REQ-023.
REQ-028 Macro LFSR_WRAP_DETECT_EN undefined SHALL tie wrap_o to 0, omit seed_q, and leave all other behaviour unchanged.

Structure
REQ-029 Package lfsr_pkg SHALL hold the maximal-length tap table (widths 4..32, as a LFSR_WIDTH-bit mask per width), the function returning the mask, and the LFSR_MIN_W=4 and LFSR_MAX_W=32 constants.
REQ-030 Sub-module lfsr_step SHALL be a combinational single-step unit, instantiated STEPS times in a chain.
REQ-031 Elaboration SHALL fatal on an illegal LFSR_WIDTH, OUT_WIDTH, STEPS or zero SEED, under translate_off.

Verification
REQ-032 Scenario (W=16, taps 16,14,13,11, SEED=1): reset, then en_i=1 for 1 cycle -> out_o=0x0002; after 11 steps -> 0x0801.
REQ-033 Scenario (same config): 65535 consecutive enabled cycles -> state back to 0x0001 and wrap_o high exactly once, with lockup_o never set.
REQ-034 Scenario (STEPS=4, SEED=1): one enabled cycle -> out_o=0x0010.
REQ-035 Scenario: load_i=1 with seed_i=0x0000 -> out_o=SEED next cycle and lockup_o pulses once; load_i=1 with en_i=1 and seed_i=0xACE1 -> out_o=0xACE1 with no step applied.
REQ-036 Scenario: after 1000 steps, load 0xACE1 -> wrap_o pulses only after 65535 further steps.
REQ-037 Scenario: rst_ni low mid-run, asynchronously between edges -> out_o=SEED immediately, and the first en_i after release gives 0x0002.
REQ-038 Scenario: OUT_WIDTH=8 with the macro undefined -> out_o equals the low byte of state and wrap_o stays 0 throughout.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator: width limits and the
// maximal-length Fibonacci tap table (one mask per register width).
// Bit n-1 of a mask is set when tap n of the polynomial is used.
package lfsr_pkg;

  localparam int LFSR_MIN_W = 4;
  localparam int LFSR_MAX_W = 32;

  typedef logic [LFSR_MAX_W-1:0] lfsr_mask_t;

  // Maximal-length tap masks for widths 4..32; zero for unsupported widths.
  function automatic lfsr_mask_t lfsr_taps(input int width);
    case (width)
      4:       return 32'h0000_000C;
      5:       return 32'h0000_0014;
      6:       return 32'h0000_0030;
      7:       return 32'h0000_0060;
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0829;
      13:      return 32'h0000_100D;
      14:      return 32'h0000_2015;
      15:      return 32'h0000_6000;
      16:      return 32'h0000_B400;
      17:      return 32'h0001_2000;
      18:      return 32'h0002_0400;
      19:      return 32'h0004_0023;
      20:      return 32'h0009_0000;
      21:      return 32'h0014_0000;
      22:      return 32'h0030_0000;
      23:      return 32'h0042_0000;
      24:      return 32'h00E1_0000;
      25:      return 32'h0120_0000;
      26:      return 32'h0200_0023;
      27:      return 32'h0400_0013;
      28:      return 32'h0900_0000;
      29:      return 32'h1400_0000;
      30:      return 32'h2000_0029;
      31:      return 32'h4800_0000;
      32:      return 32'h8020_0003;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single-step Fibonacci LFSR unit: shifts left by one and
// feeds the XOR of the tapped bits into bit 0.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] state_o
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  // One shift with the feedback bit formed from the tap mask.
  always_comb begin
    state_o = {state_i[WIDTH-2:0], ^(state_i & TAPS)};
  end

endmodule

// File: rtl/lfsr_gen.sv
// Configurable Fibonacci LFSR generator with runtime seed load, all-zero
// lockup recovery and optional wrap detection.
// Optional feature macro: LFSR_WRAP_DETECT_EN (wrap_o tied low when undefined).
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH = 16,
  parameter int                    OUT_WIDTH  = 16,
  parameter int                    STEPS      = 1,
  parameter logic [LFSR_WIDTH-1:0] SEED       = LFSR_WIDTH'(1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [LFSR_WIDTH-1:0] seed_i,
  output logic [OUT_WIDTH-1:0]  out_o,
  output logic                  lockup_o,
  output logic                  wrap_o
);

  if (LFSR_WIDTH < LFSR_MIN_W || LFSR_WIDTH > LFSR_MAX_W) begin : g_bad_width
    $fatal(1, "lfsr_gen: LFSR_WIDTH out of range 4..32");
  end
  if (OUT_WIDTH < 1 || OUT_WIDTH > LFSR_WIDTH) begin : g_bad_out_width
    $fatal(1, "lfsr_gen: OUT_WIDTH out of range 1..LFSR_WIDTH");
  end
  if (STEPS < 1 || STEPS > LFSR_WIDTH) begin : g_bad_steps
    $fatal(1, "lfsr_gen: STEPS out of range 1..LFSR_WIDTH");
  end
  if (SEED == '0) begin : g_bad_seed
    $fatal(1, "lfsr_gen: SEED must be nonzero");
  end

  logic [LFSR_WIDTH-1:0] state_q, state_d;
  logic                  lockup_q, lockup_d;
  logic [LFSR_WIDTH-1:0] step_chain [STEPS+1];

  assign step_chain[0] = state_q;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    lfsr_step #(
      .WIDTH(LFSR_WIDTH)
    ) u_step (
      .state_i(step_chain[g]),
      .state_o(step_chain[g+1])
    );
  end

  // Next state: zero-state recovery, then load (zero seed maps to SEED), then step.
  always_comb begin
    state_d  = state_q;
    lockup_d = 1'b0;
    if (state_q == '0) begin
      state_d  = SEED;
      lockup_d = 1'b1;
    end else if (load_i) begin
      if (seed_i == '0) begin
        state_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        state_d = seed_i;
      end
    end else if (en_i) begin
      state_d = step_chain[STEPS];
    end
  end

  // State and lockup pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= SEED;
      lockup_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lockup_q <= lockup_d;
    end
  end

  assign out_o    = state_q[OUT_WIDTH-1:0];
  assign lockup_o = lockup_q;

`ifdef LFSR_WRAP_DETECT_EN
  logic [LFSR_WIDTH-1:0] seed_q, seed_d;
  logic                  wrap_q, wrap_d;

  // Track the effective loaded seed and flag a step landing back on it.
  always_comb begin
    seed_d = seed_q;
    wrap_d = 1'b0;
    if (state_q != '0) begin
      if (load_i) begin
        seed_d = state_d;
      end else if (en_i) begin
        wrap_d = (state_d == seed_q);
      end
    end
  end

  // Seed memory and wrap pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      seed_q <= SEED;
      wrap_q <= 1'b0;
    end else begin
      seed_q <= seed_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap_o = wrap_q;
`else
  assign wrap_o = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: four instances (16-bit single step,
// 16-bit four steps, 16-bit with 8-bit output, 8-bit single step) share one
// stimulus stream and are compared every cycle against a tap-list model.
module tb_lfsr_gen;

`ifdef LFSR_WRAP_DETECT_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] seed;

  logic [15:0] out_a, out_b;
  logic [7:0]  out_c, out_d;
  logic        lock_a, lock_b, lock_c, lock_d;
  logic        wrap_a, wrap_b, wrap_c, wrap_d;

  lfsr_gen #(.LFSR_WIDTH(16), .OUT_WIDTH(16), .STEPS(1), .SEED(16'h0001)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .load_i(load), .seed_i(seed),
    .out_o(out_a), .lockup_o(lock_a), .wrap_o(wrap_a));

  lfsr_gen #(.LFSR_WIDTH(16), .OUT_WIDTH(16), .STEPS(4), .SEED(16'h0001)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .load_i(load), .seed_i(seed),
    .out_o(out_b), .lockup_o(lock_b), .wrap_o(wrap_b));

  lfsr_gen #(.LFSR_WIDTH(16), .OUT_WIDTH(8), .STEPS(1), .SEED(16'h0001)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .load_i(load), .seed_i(seed),
    .out_o(out_c), .lockup_o(lock_c), .wrap_o(wrap_c));

  lfsr_gen #(.LFSR_WIDTH(8), .OUT_WIDTH(8), .STEPS(1), .SEED(8'h01)) u_d (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .load_i(load), .seed_i(seed[7:0]),
    .out_o(out_d), .lockup_o(lock_d), .wrap_o(wrap_d));

  logic [31:0] dut_out  [4];
  logic        dut_lock [4];
  logic        dut_wrap [4];

  assign dut_out[0]  = {16'h0, out_a};
  assign dut_out[1]  = {16'h0, out_b};
  assign dut_out[2]  = {24'h0, out_c};
  assign dut_out[3]  = {24'h0, out_d};
  assign dut_lock[0] = lock_a;
  assign dut_lock[1] = lock_b;
  assign dut_lock[2] = lock_c;
  assign dut_lock[3] = lock_d;
  assign dut_wrap[0] = wrap_a;
  assign dut_wrap[1] = wrap_b;
  assign dut_wrap[2] = wrap_c;
  assign dut_wrap[3] = wrap_d;

  logic [31:0] m_state [4];
  logic [31:0] m_last  [4];
  logic        m_lock  [4];
  logic        m_wrap  [4];

  int errors = 0;
  int checks = 0;
  int wrap_cnt [4];
  int lock_cnt [4];
  bit done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_w(input int k);
    return (k == 3) ? 8 : 16;
  endfunction

  function automatic int cfg_steps(input int k);
    return (k == 1) ? 4 : 1;
  endfunction

  function automatic int cfg_outw(input int k);
    return (k >= 2) ? 8 : 16;
  endfunction

  function automatic logic [31:0] width_mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  // Polynomial taps written as 1-based positions, as in the datasheet lists.
  function automatic logic [31:0] model_step(input int w, input logic [31:0] s);
    int   taps [4];
    logic fb;
    if (w == 8) taps = '{8, 6, 5, 4};
    else        taps = '{16, 14, 13, 11};
    fb = 1'b0;
    for (int i = 0; i < 4; i++) fb = fb ^ s[taps[i]-1];
    return ((s << 1) | {31'b0, fb}) & width_mask(w);
  endfunction

  function automatic logic [31:0] model_advance(input int w, input int n, input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < n; i++) r = model_step(w, r);
    return r;
  endfunction

  // Reference model: one entry per instance, updated on the same events as the DUTs.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        m_state[k] <= 32'h1;
        m_last[k]  <= 32'h1;
        m_lock[k]  <= 1'b0;
        m_wrap[k]  <= 1'b0;
      end else begin
        m_lock[k] <= 1'b0;
        m_wrap[k] <= 1'b0;
        if (m_state[k] == 32'h0) begin
          m_state[k] <= 32'h1;
          m_lock[k]  <= 1'b1;
        end else if (load) begin
          if (({16'h0, seed} & width_mask(cfg_w(k))) == 32'h0) begin
            m_state[k] <= 32'h1;
            m_last[k]  <= 32'h1;
            m_lock[k]  <= 1'b1;
          end else begin
            m_state[k] <= {16'h0, seed} & width_mask(cfg_w(k));
            m_last[k]  <= {16'h0, seed} & width_mask(cfg_w(k));
          end
        end else if (en) begin
          m_state[k] <= model_advance(cfg_w(k), cfg_steps(k), m_state[k]);
          m_wrap[k]  <= WRAP_ON && (model_advance(cfg_w(k), cfg_steps(k), m_state[k]) == m_last[k]);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int k, input logic [31:0] got,
                             input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got 0x%0h, expected 0x%0h at %0t", name, k, got, want, $time);
    end
  endtask

  // Drive the inputs for n rising edges, then drop en/load.
  task automatic applyStimulus(input bit e, input bit l, input logic [15:0] s, input int n);
    en   = e;
    load = l;
    seed = s;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    en   = 1'b0;
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    seed  = 16'h0;
    for (int k = 0; k < 4; k++) begin
      wrap_cnt[k] = 0;
      lock_cnt[k] = 0;
    end
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    fork
      begin
        while (!done) begin
          @(negedge clk);
          for (int k = 0; k < 4; k++) begin
            checkOutput("cyc_out", k, dut_out[k], m_state[k] & width_mask(cfg_outw(k)));
            checkOutput("cyc_lockup", k, 32'(dut_lock[k]), 32'(m_lock[k]));
            checkOutput("cyc_wrap", k, 32'(dut_wrap[k]), 32'(m_wrap[k]));
            wrap_cnt[k] += int'(dut_wrap[k]);
            lock_cnt[k] += int'(dut_lock[k]);
          end
        end
      end
      begin
        checkOutput("reset_out", 0, dut_out[0], 32'h0001);
        checkOutput("reset_out", 3, dut_out[3], 32'h01);
        checkOutput("reset_lockup", 0, 32'(dut_lock[0]), 32'h0);
        checkOutput("reset_wrap", 0, 32'(dut_wrap[0]), 32'h0);

        applyStimulus(1'b1, 1'b0, 16'h0, 1);
        checkOutput("first_step", 0, dut_out[0], 32'h0002);
        checkOutput("steps4_first", 1, dut_out[1], 32'h0010);
        checkOutput("low_byte_first", 2, dut_out[2], 32'h02);
        checkOutput("w8_first", 3, dut_out[3], 32'h02);

        applyStimulus(1'b1, 1'b0, 16'h0, 10);
        checkOutput("eleven_steps", 0, dut_out[0], 32'h0801);
        checkOutput("eleven_low_byte", 2, dut_out[2], 32'h01);

        applyStimulus(1'b1, 1'b1, 16'h0000, 1);
        checkOutput("zero_load_out", 0, dut_out[0], 32'h0001);
        checkOutput("zero_load_lockup", 0, 32'(dut_lock[0]), 32'h1);
        checkOutput("zero_load_wrap", 0, 32'(dut_wrap[0]), 32'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 1);
        checkOutput("lockup_one_cycle", 0, 32'(dut_lock[0]), 32'h0);

        applyStimulus(1'b1, 1'b1, 16'hACE1, 1);
        checkOutput("load_no_step", 0, dut_out[0], 32'hACE1);
        checkOutput("load_no_step", 1, dut_out[1], 32'hACE1);
        checkOutput("load_no_step", 3, dut_out[3], 32'hE1);
        checkOutput("load_wrap", 0, 32'(dut_wrap[0]), 32'h0);

        applyStimulus(1'b0, 1'b0, 16'h1234, 3);
        checkOutput("hold", 0, dut_out[0], 32'hACE1);

        applyStimulus(1'b1, 1'b0, 16'h0, 5);
        en   = 1'b1;
        load = 1'b1;
        seed = 16'h5555;
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out", 0, dut_out[0], 32'h0001);
        checkOutput("async_reset_out", 1, dut_out[1], 32'h0001);
        @(posedge clk);
        #1;
        en    = 1'b0;
        load  = 1'b0;
        rst_n = 1'b1;
        checkOutput("reset_discard", 0, dut_out[0], 32'h0001);
        applyStimulus(1'b1, 1'b0, 16'h0, 1);
        checkOutput("step_after_reset", 0, dut_out[0], 32'h0002);

        applyStimulus(1'b1, 1'b0, 16'h0, 1000);
        applyStimulus(1'b0, 1'b1, 16'hACE1, 1);
        checkOutput("w8_load", 3, dut_out[3], 32'hE1);
        for (int k = 0; k < 4; k++) wrap_cnt[k] = 0;
        applyStimulus(1'b1, 1'b0, 16'h0, 254);
        checkOutput("w8_no_early_wrap", 3, 32'(wrap_cnt[3]), 32'h0);
        checkOutput("w8_no_early_wrap_now", 3, 32'(dut_wrap[3]), 32'h0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1);
        checkOutput("w8_wrap_pulse", 3, 32'(dut_wrap[3]), 32'(WRAP_ON));
        checkOutput("w8_back_to_seed", 3, dut_out[3], 32'hE1);

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
          wrap_cnt[k] = 0;
          lock_cnt[k] = 0;
        end
        applyStimulus(1'b1, 1'b0, 16'h0, 65535);
        checkOutput("period_state", 0, dut_out[0], 32'h0001);
        checkOutput("period_state", 1, dut_out[1], 32'h0001);
        @(posedge clk);
        #1;
        checkOutput("period_wrap_count", 0, 32'(wrap_cnt[0]), WRAP_ON ? 32'h1 : 32'h0);
        checkOutput("period_wrap_count", 1, 32'(wrap_cnt[1]), WRAP_ON ? 32'h1 : 32'h0);
        checkOutput("period_wrap_count", 2, 32'(wrap_cnt[2]), WRAP_ON ? 32'h1 : 32'h0);
        checkOutput("period_lockup_count", 0, 32'(lock_cnt[0]), 32'h0);
        checkOutput("wrap_dropped", 0, 32'(dut_wrap[0]), 32'h0);
        done = 1'b1;
      end
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
